// File: rtl/packet_reader_pkg.sv
// Shared constants and FSM state encoding for the packet memory reader.
// Latency: n/a (types only); backpressure: n/a.
package snn_pkg;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;
endpackage

// File: rtl/packet_reader_if.sv
// Memory read port plus packet valid/ready stream between reader and its neighbours.
// Latency: n/a (wiring only); backpressure: pkt_ready from the consumer side.
interface packet_reader_if #(
  parameter int ADDR_W = snn_pkg::ADDR_W,
  parameter int DATA_W = snn_pkg::DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_valid;
  logic              pkt_ready;
  logic              pkt_last;

  modport master (
    output mem_addr, pkt_data, pkt_valid, pkt_last,
    input  mem_data, pkt_ready
  );

  modport slave (
    input  mem_addr, pkt_data, pkt_valid, pkt_last,
    output mem_data, pkt_ready
  );
endinterface

// File: rtl/packet_reader_fifo.sv
// Two-entry FIFO with combinational head; push and pop may coincide when full or empty.
// Latency: push visible at head the cycle after; backpressure: push ignored when full without pop.
module pkt_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a push if the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = entry[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/packet_reader.sv
// Streams a run of packets from the packet memory to a valid/ready consumer, yielding to write_mode.
// Latency: first packet valid 2 edges after start; backpressure: credit-limited issue into a 2-entry FIFO.
module packet_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_mode,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  packet_reader_if.master   bus
);
  import snn_pkg::*;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] ONE_COUNT = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   count_clamped;
  logic              inflight;
  logic              inflight_last;
  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2:0]        occupancy;
  logic [2:0]        credit_limit;
  logic              pop;
  logic              issue;
  logic              final_xfer;
  logic              launch;

  assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign pop           = bus.pkt_valid & bus.pkt_ready;
  assign launch        = (state == IDLE) & start & ~abort;

  // A slot must be free for the read returning next cycle, counting the pop happening now.
  assign occupancy    = {1'b0, fifo_count} + {2'b00, inflight};
  assign credit_limit = 3'(FIFO_DEPTH) + {2'b00, pop};
  assign issue = (state == FETCH) & ~write_mode & ~abort & (remaining != '0)
               & (fifo_full ? (pop & ~inflight) : (occupancy < credit_limit));

  assign final_xfer = (state == DRAIN) & pop & bus.pkt_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && count_clamped != '0) state_nxt = FETCH;
      FETCH:   if (issue && remaining == ONE_COUNT) state_nxt = DRAIN;
      DRAIN:   if (final_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue & (remaining == ONE_COUNT);
      done          <= ~abort & ((launch & (count_clamped == '0)) | final_xfer);
      if (launch) begin
        rd_ptr    <= base_addr;
        remaining <= count_clamped;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        remaining <= remaining - ONE_COUNT;
      end
    end
  end

  // Read data is pushed unconditionally; abort flushes it together with the FIFO contents.
  pkt_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (inflight),
    .push_data ({inflight_last, bus.mem_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.mem_addr  = rd_ptr;
  assign bus.pkt_valid = ~fifo_empty;
  assign bus.pkt_data  = fifo_head[DATA_W-1:0];
  assign bus.pkt_last  = ~fifo_empty & fifo_head[DATA_W];
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_packet_reader.sv
// Directed bench for packet_reader: memory model holds 0xA0+i, each task checks one scenario.
module tb_packet_reader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       write_mode;
  logic       start;
  logic       abort;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  logic [7:0] got_q [$];
  logic       last_q [$];
  bit         fin;

  packet_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  packet_reader #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_mode (write_mode),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  task automatic kick(input logic [3:0] b, input logic [4:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic collect(input int budget);
    got_q.delete();
    last_q.delete();
    fin = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      if (done) fin = 1;
      else begin
        if (bus.pkt_valid && bus.pkt_ready) begin
          got_q.push_back(bus.pkt_data);
          last_q.push_back(bus.pkt_last);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; write_mode = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; count = '0; bus.pkt_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bus.pkt_valid, bus.pkt_last} !== 4'b0000 || bus.mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: busy/done/valid/last=%b addr=%h expected 0000 addr=0",
               {busy, done, bus.pkt_valid, bus.pkt_last}, bus.mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run;
    logic [7:0] exp;
    bus.pkt_ready = 1'b1;
    kick(4'd0, 5'd16);
    checks++;
    if (busy !== 1'b1 || bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL full_after_start: busy=%b valid=%b expected 1 0", busy, bus.pkt_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL full_first_latency: valid=%b before E2, expected 0", bus.pkt_valid);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = 8'(8'hA0 + i);
      checks++;
      if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== exp || bus.pkt_last !== (i == 15) || done !== 1'b0) begin
        errors++;
        $display("FAIL full_pkt[%0d]: valid=%b data=%h last=%b done=%b expected 1 %h %b 0",
                 i, bus.pkt_valid, bus.pkt_data, bus.pkt_last, done, exp, (i == 15));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL full_done: done=%b busy=%b valid=%b expected 1 0 0", done, busy, bus.pkt_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL full_done_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp;
    bus.pkt_ready = 1'b1;
    kick(4'd14, 5'd4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = 8'(8'hA0 + ((14 + i) % 16));
      checks++;
      if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== exp || bus.pkt_last !== (i == 3)) begin
        errors++;
        $display("FAIL wrap_pkt[%0d]: valid=%b data=%h last=%b expected 1 %h %b",
                 i, bus.pkt_valid, bus.pkt_data, bus.pkt_last, exp, (i == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wrap_done: done=%b expected 1", done);
    end
  endtask

  task automatic test_backpressure;
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    logic [3:0] prev_addr = 4'd5;
    int         issued = 0;
    int         xfers = 0;
    int         cyc = 0;
    bit         seen_done = 0;
    got_q.delete();
    last_q.delete();
    bus.pkt_ready = 1'b1;
    kick(4'd5, 5'd5);
    checks++;
    if (bus.mem_addr !== 4'd5) begin
      errors++; $display("FAIL bp_base_latch: addr=%h expected 5", bus.mem_addr);
    end
    while (!seen_done && cyc < 60) begin
      if (stalled) begin
        checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== held) begin
          errors++; $display("FAIL bp_stable: valid=%b data=%h expected 1 %h", bus.pkt_valid, bus.pkt_data, held);
        end
      end
      if (bus.mem_addr !== prev_addr) begin
        issued++;
        prev_addr = bus.mem_addr;
      end
      checks++;
      if (issued - xfers > 2) begin
        errors++; $display("FAIL bp_credit: outstanding=%0d expected <=2", issued - xfers);
      end
      if (done) seen_done = 1;
      else begin
        bus.pkt_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        stalled = bus.pkt_valid && !bus.pkt_ready;
        held    = bus.pkt_data;
        if (bus.pkt_valid && bus.pkt_ready) begin
          got_q.push_back(bus.pkt_data);
          last_q.push_back(bus.pkt_last);
          xfers++;
        end
        cyc++;
        @(negedge clk);
      end
    end
    checks++;
    if (!seen_done || got_q.size() != 5 || issued != 5) begin
      errors++;
      $display("FAIL bp_totals: done_seen=%0d packets=%0d issues=%0d expected 1 5 5", seen_done, got_q.size(), issued);
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      checks++;
      if (got_q[i] !== 8'(8'hA5 + i) || last_q[i] !== (i == 4)) begin
        errors++;
        $display("FAIL bp_pkt[%0d]: data=%h last=%b expected %h %b", i, got_q[i], last_q[i], 8'(8'hA5 + i), (i == 4));
      end
    end
    bus.pkt_ready = 1'b1;
  endtask

  task automatic test_write_mode;
    bit seen_done = 0;
    got_q.delete();
    last_q.delete();
    bus.pkt_ready = 1'b1;
    kick(4'd0, 5'd6);
    @(negedge clk);
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (c == 0) write_mode = 1'b1;
      if (c == 3) write_mode = 1'b0;
      if (c >= 1 && c <= 3) begin
        checks++;
        if (bus.mem_addr !== 4'd1) begin
          errors++; $display("FAIL wm_addr_frozen[%0d]: addr=%h expected 1", c, bus.mem_addr);
        end
      end
      if (c == 1) begin
        checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 8'hA0) begin
          errors++; $display("FAIL wm_inflight: valid=%b data=%h expected 1 a0", bus.pkt_valid, bus.pkt_data);
        end
      end
      if (done) seen_done = 1;
      else begin
        if (bus.pkt_valid && bus.pkt_ready) begin
          got_q.push_back(bus.pkt_data);
          last_q.push_back(bus.pkt_last);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!seen_done || got_q.size() != 6) begin
      errors++; $display("FAIL wm_totals: done_seen=%0d packets=%0d expected 1 6", seen_done, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      checks++;
      if (got_q[i] !== 8'(8'hA0 + i) || last_q[i] !== (i == 5)) begin
        errors++;
        $display("FAIL wm_pkt[%0d]: data=%h last=%b expected %h %b", i, got_q[i], last_q[i], 8'(8'hA0 + i), (i == 5));
      end
    end
  endtask

  task automatic test_count_zero;
    kick(4'd9, 5'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b valid=%b expected 1 0 0", done, busy, bus.pkt_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after: done=%b busy=%b valid=%b expected 0 0 0", done, busy, bus.pkt_valid);
    end
  endtask

  task automatic test_start_busy;
    bus.pkt_ready = 1'b1;
    kick(4'd8, 5'd3);
    base_addr = 4'd0; count = 5'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(30);
    checks++;
    if (!fin || got_q.size() != 3) begin
      errors++; $display("FAIL busy_start_totals: done_seen=%0d packets=%0d expected 1 3", fin, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      checks++;
      if (got_q[i] !== 8'(8'hA8 + i) || last_q[i] !== (i == 2)) begin
        errors++;
        $display("FAIL busy_start_pkt[%0d]: data=%h last=%b expected %h %b", i, got_q[i], last_q[i], 8'(8'hA8 + i), (i == 2));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL busy_start_idle: busy=%b valid=%b expected 0 0", busy, bus.pkt_valid);
    end
  endtask

  task automatic test_clamp;
    bus.pkt_ready = 1'b1;
    kick(4'd0, 5'd20);
    collect(40);
    checks++;
    if (!fin || got_q.size() != 16) begin
      errors++; $display("FAIL clamp_totals: done_seen=%0d packets=%0d expected 1 16", fin, got_q.size());
    end else if (got_q[15] !== 8'hAF || last_q[15] !== 1'b1) begin
      errors++; $display("FAIL clamp_last: data=%h last=%b expected af 1", got_q[15], last_q[15]);
    end
  endtask

  task automatic test_abort;
    bus.pkt_ready = 1'b1;
    kick(4'd0, 5'd16);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 8'hA0) begin
      errors++; $display("FAIL abort_pkt0: valid=%b data=%h expected 1 a0", bus.pkt_valid, bus.pkt_data);
    end
    @(negedge clk);
    checks++;
    if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 8'hA1) begin
      errors++; $display("FAIL abort_pkt1: valid=%b data=%h expected 1 a1", bus.pkt_valid, bus.pkt_data);
    end
    @(negedge clk);
    abort = 1'b1; bus.pkt_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, bus.pkt_valid, bus.pkt_last} !== 4'b0000) begin
      errors++; $display("FAIL abort_flush: busy/done/valid/last=%b expected 0000", {busy, done, bus.pkt_valid, bus.pkt_last});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      errors++; $display("FAIL abort_inflight: done=%b valid=%b expected 0 0", done, bus.pkt_valid);
    end
    bus.pkt_ready = 1'b1;
    kick(4'd3, 5'd2);
    collect(20);
    checks++;
    if (!fin || got_q.size() != 2) begin
      errors++; $display("FAIL abort_rerun_totals: done_seen=%0d packets=%0d expected 1 2", fin, got_q.size());
    end else if (got_q[0] !== 8'hA3 || got_q[1] !== 8'hA4 || last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_rerun_pkts: data=%h,%h last=%b%b expected a3,a4 01", got_q[0], got_q[1], last_q[0], last_q[1]);
    end
  endtask

  task automatic test_async_reset;
    bus.pkt_ready = 1'b0;
    kick(4'd5, 5'd16);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pkt_valid !== 1'b1 || bus.mem_addr !== 4'd7) begin
      errors++; $display("FAIL arst_pre: valid=%b addr=%h expected 1 7", bus.pkt_valid, bus.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.pkt_valid, bus.pkt_last} !== 4'b0000 || bus.mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL arst_values: busy/done/valid/last=%b addr=%h expected 0000 addr=0",
               {busy, done, bus.pkt_valid, bus.pkt_last}, bus.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    test_reset();
    test_full_run();
    test_wrap();
    test_backpressure();
    test_write_mode();
    test_count_zero();
    test_start_busy();
    test_clamp();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_reader.md
Name: packet_reader

Overview:
Sequencer that reads a run of 8-bit packets out of the 16-entry packet memory and streams them to a consumer over a valid/ready interface. It drives the internal memory address (addr_int) and sits between Memory and the Multilayer datapath, or a readback path to uo_out.
It yields the memory whenever write_mode is high. A 2-entry output FIFO absorbs the 1-cycle memory read latency and consumer backpressure.

Parameters:
ADDR_W, 4, memory address width; the address space wraps modulo 2^ADDR_W
DATA_W, 8, packet width
FIFO_DEPTH, 2, output buffer entries; fixed at 2, and other values are unsupported

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
write_mode  input  1  1 = memory owned by the external writer; reader stalls
start  input  1  pulse; begin a run (sampled only in IDLE)
abort  input  1  synchronous cancel of the current run
base_addr  input  ADDR_W  first address of the run (sampled with start)
count  input  ADDR_W+1  number of packets, 0..16 (sampled with start)
mem_addr  output  ADDR_W  address to Memory (becomes addr_int)
mem_data  input  DATA_W  Memory read data; valid 1 cycle after the address is presented
pkt_data  output  DATA_W  head-of-FIFO packet
pkt_valid  output  1  pkt_data valid
pkt_ready  input  1  consumer accepts; transfer = pkt_valid & pkt_ready
pkt_last  output  1  pkt_data is the final packet of the run
busy  output  1  high in FETCH/DRAIN
done  output  1  1-cycle pulse at run completion

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state is cleared by reset.
- Reset values: state=IDLE; mem_addr=0; pkt_valid=0; pkt_last=0; busy=0; done=0; FIFO empty; inflight=0.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 with count>0: latch rd_ptr=base_addr and remaining=count, go to FETCH.
  - start=1 with count=0: done pulses the next cycle and the FSM stays in IDLE.
- Memory reads:
  - mem_addr is a register equal to rd_ptr.
  - A read issues in a FETCH cycle when all of these hold: write_mode=0, remaining>0, and (fifo_count + inflight − pop) < 2, where pop = pkt_valid & pkt_ready.
  - On issue: rd_ptr increments modulo 16 (15 wraps to 0), remaining decrements, inflight is set for the next cycle.
- Read return: in the cycle after an issue, mem_data is written into the FIFO unconditionally. The issue qualification guarantees space.
- Stall and latency:
  - write_mode=1 only stalls new issues. A read issued while write_mode=0 completes normally.
  - Latency: start sampled at edge E0; read issued in the cycle after E0; data written at E2; pkt_valid=1 from E2 onward.
  - With pkt_ready held high, throughput is one packet per cycle.
- FETCH to DRAIN: when remaining reaches 0, go to DRAIN.
- DRAIN: wait for inflight=0 and FIFO empty. done pulses in the cycle after the final transfer; the FSM returns to IDLE in that same cycle.
- pkt_last: high exactly while the head entry is the run's final packet, using a tag bit stored per FIFO entry.
- FIFO handshake:
  - pkt_data and pkt_valid are held stable while pkt_valid=1 and pkt_ready=0.
  - A simultaneous FIFO push and pop is allowed, full or empty.
- start while busy: ignored.
- abort=1 in any state:
  - Next cycle: FIFO flushed, inflight data discarded, go to IDLE.
  - pkt_valid=0, and no done pulse.
  - abort has priority over start in the same cycle.
- Widths: count is ADDR_W+1 bits so that 16 is representable. Values above 16 are clamped to 16.

Decomposition:
- Shared package (snn_pkg):
  - ADDR_W, DATA_W and the depth constant 16.
  - The state enum {IDLE, FETCH, DRAIN}.
- Natural sub-module: pkt_fifo2, a 2-entry FIFO of DATA_W+1 bits (data plus last tag) with push, pop, count, full and empty.
- The top of packet_reader holds the FSM, pointer and credit logic.

Test Plan:
- Memory preloaded with mem[i]=0xA0+i. Stimulus: start, base=0, count=16, ready=1. Required: pkt_data 0xA0..0xAF on consecutive cycles; first valid at E2; pkt_last only with 0xAF; done 1 cycle after.
- Wrap: base=14, count=4. Required: 0xAE, 0xAF, 0xA0, 0xA1 in order; pkt_last on 0xA1.
- Backpressure: count=5, ready toggling 1,0,0,1,... Required: no drops or duplicates; data stable while stalled; issues never exceed fifo+inflight=2.
- write_mode held high for 3 cycles mid-run. Required: mem_addr frozen and no issues during the hold; an in-flight read before the hold still delivered; sequence intact.
- Edge requests:
  - count=0 start: done pulses once, pkt_valid stays 0.
  - start while busy: ignored.
- abort after 2 transfers: FIFO flushed, IDLE next cycle, no done. A new run with base=3, count=2 then yields 0xA3, 0xA4.
- rst_n low mid-run: all outputs at reset values immediately (asynchronous).
